// File: rtl/ibex_pkg_pext.sv
// Shared types, lane-count constants and operand-extension helpers for the
// P-extension SIMD multiply-accumulate unit.
package ibex_pkg_pext;

  typedef enum logic [1:0] {
    MAC_IDLE,
    MAC_LANE,
    MAC_FIN,
    MAC_DONE
  } pext_mac_state_e;

  typedef enum logic [1:0] {
    MAC_W8,
    MAC_W16,
    MAC_W32
  } pext_mac_width_e;

  localparam int unsigned PEXT_LANES8  = 4;
  localparam int unsigned PEXT_LANES16 = 2;
  localparam int unsigned PEXT_PP32    = 4;

  // Extend an 8-bit lane to the 17-bit multiplier operand width.
  function automatic logic [16:0] pext_ext8(input logic [7:0] v, input logic sgn);
    return {{9{sgn & v[7]}}, v};
  endfunction

  // Extend a 16-bit lane/half to the 17-bit multiplier operand width.
  function automatic logic [16:0] pext_ext16(input logic [15:0] v, input logic sgn);
    return {sgn & v[15], v};
  endfunction

endpackage

// File: rtl/ibex_pext_simd_mac_if.sv
// Request/response bundle between EX issue logic (master) and the SIMD MAC (slave).
interface ibex_pext_simd_mac_if;
  logic        valid_i;
  logic        ready_o;
  logic        kill_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] op_c_i;
  logic        width32_i;
  logic        width8_i;
  logic        signed_ops_i;
  logic        sub_i;
  logic        sat_i;
  logic        rounding_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        ov_set_o;

  modport master (
    output valid_i, kill_i, op_a_i, op_b_i, op_c_i, width32_i, width8_i,
           signed_ops_i, sub_i, sat_i, rounding_i, ready_i,
    input  ready_o, valid_o, result_o, ov_set_o
  );

  modport slave (
    input  valid_i, kill_i, op_a_i, op_b_i, op_c_i, width32_i, width8_i,
           signed_ops_i, sub_i, sat_i, rounding_i, ready_i,
    output ready_o, valid_o, result_o, ov_set_o
  );
endinterface

// File: rtl/ibex_pext_mul17.sv
// Combinational 17x17 signed multiplier; callers pre-extend operands so the
// same block serves signed and unsigned 16-bit (or narrower) operands.
module ibex_pext_mul17 (
  input  logic [16:0] a_i,
  input  logic [16:0] b_i,
  output logic [33:0] p_o
);
  assign p_o = 34'($signed(a_i)) * 34'($signed(b_i));
endmodule

// File: rtl/ibex_pext_simd_mac.sv
// Multi-cycle SIMD multiply-accumulate: one lane (or one 16x16 partial product
// in 32-bit mode) per cycle through a shared 17x17 multiplier.
module ibex_pext_simd_mac #(
  parameter bit RoundEnable = 1'b1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ibex_pext_simd_mac_if.slave  mac_if
);
  import ibex_pkg_pext::*;

  pext_mac_state_e state_q;
  pext_mac_width_e width_q;
  logic [1:0]  cnt_q;
  logic [31:0] a_q, b_q, c_q, result_q;
  logic        sgn_q, sub_q, sat_q, rnd_q, ov_q, valid_q, ready_q;
  logic [65:0] acc_q;

  logic [16:0] mul_a, mul_b;
  logic [33:0] prod, lane_rnd;
  logic        is_w8, last_lane, lane_ov, fin_ov;
  logic [15:0] hi16, c16, lane_sat;
  logic [7:0]  hi8, c8;
  logic [17:0] p18, c18, r18, smax, smin, umax;
  logic [31:0] lane_result_d, hi32, fin_res;
  logic [65:0] pp66, pp_sh, acc_d;
  logic [33:0] p34, c34, r34;

  assign is_w8 = (width_q == MAC_W8);
  assign last_lane = (width_q == MAC_W8)  ? (cnt_q == 2'(PEXT_LANES8 - 1))  :
                     (width_q == MAC_W16) ? (cnt_q == 2'(PEXT_LANES16 - 1)) :
                                            (cnt_q == 2'(PEXT_PP32 - 1));

  // Select multiplier operands for the current lane or partial product.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (width_q)
      MAC_W8: begin
        mul_a = pext_ext8(a_q[{cnt_q, 3'b000} +: 8], sgn_q);
        mul_b = pext_ext8(b_q[{cnt_q, 3'b000} +: 8], sgn_q);
      end
      MAC_W16: begin
        mul_a = pext_ext16(a_q[{cnt_q[0], 4'b0000} +: 16], sgn_q);
        mul_b = pext_ext16(b_q[{cnt_q[0], 4'b0000} +: 16], sgn_q);
      end
      default: begin
        // Low halves are always unsigned; only the high halves carry the sign.
        mul_a = cnt_q[1] ? pext_ext16(a_q[31:16], sgn_q) : {1'b0, a_q[15:0]};
        mul_b = cnt_q[0] ? pext_ext16(b_q[31:16], sgn_q) : {1'b0, b_q[15:0]};
      end
    endcase
  end

  ibex_pext_mul17 u_mul17 (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  // 8/16-bit lane: round, take high half, accumulate at W+2 bits, saturate.
  always_comb begin
    lane_rnd = '0;
    if (rnd_q) lane_rnd = is_w8 ? 34'h80 : 34'h8000;
    hi16 = 16'((prod + lane_rnd) >> 16);
    hi8  = 8'((prod + lane_rnd) >> 8);
    c8   = c_q[{cnt_q, 3'b000} +: 8];
    c16  = c_q[{cnt_q[0], 4'b0000} +: 16];
    if (is_w8) begin
      p18  = {{10{sgn_q & hi8[7]}}, hi8};
      c18  = {{10{sgn_q & c8[7]}}, c8};
      smax = 18'h0007F;
      smin = 18'h3FF80;
      umax = 18'h000FF;
    end else begin
      p18  = {{2{sgn_q & hi16[15]}}, hi16};
      c18  = {{2{sgn_q & c16[15]}}, c16};
      smax = 18'h07FFF;
      smin = 18'h38000;
      umax = 18'h0FFFF;
    end
    r18      = sub_q ? (c18 - p18) : (c18 + p18);
    lane_sat = r18[15:0];
    lane_ov  = 1'b0;
    if (sat_q) begin
      if (sgn_q) begin
        if ($signed(r18) > $signed(smax)) begin
          lane_sat = smax[15:0];
          lane_ov  = 1'b1;
        end else if ($signed(r18) < $signed(smin)) begin
          lane_sat = smin[15:0];
          lane_ov  = 1'b1;
        end
      end else begin
        if (r18[17]) begin
          lane_sat = '0;
          lane_ov  = 1'b1;
        end else if (r18 > umax) begin
          lane_sat = umax[15:0];
          lane_ov  = 1'b1;
        end
      end
    end
    lane_result_d = result_q;
    if (is_w8) lane_result_d[{cnt_q, 3'b000} +: 8] = lane_sat[7:0];
    else       lane_result_d[{cnt_q[0], 4'b0000} +: 16] = lane_sat;
  end

  // 32-bit mode: shift/accumulate partial products, then finalise the lane.
  always_comb begin
    pp66 = {{32{prod[33]}}, prod};
    unique case (cnt_q)
      2'd0:    pp_sh = pp66;
      2'd3:    pp_sh = pp66 << 32;
      default: pp_sh = pp66 << 16;
    endcase
    acc_d   = acc_q + pp_sh;
    hi32    = 32'((acc_q + {34'd0, rnd_q, 31'd0}) >> 32);
    p34     = {{2{sgn_q & hi32[31]}}, hi32};
    c34     = {{2{sgn_q & c_q[31]}}, c_q};
    r34     = sub_q ? (c34 - p34) : (c34 + p34);
    fin_res = r34[31:0];
    fin_ov  = 1'b0;
    if (sat_q) begin
      if (sgn_q) begin
        if ($signed(r34) > $signed(34'h0_7FFF_FFFF)) begin
          fin_res = 32'h7FFF_FFFF;
          fin_ov  = 1'b1;
        end else if ($signed(r34) < $signed(34'h3_8000_0000)) begin
          fin_res = 32'h8000_0000;
          fin_ov  = 1'b1;
        end
      end else begin
        if (r34[33]) begin
          fin_res = '0;
          fin_ov  = 1'b1;
        end else if (r34[32]) begin
          fin_res = '1;
          fin_ov  = 1'b1;
        end
      end
    end
  end

  // Control FSM with registered handshake outputs; kill overrides everything but reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= MAC_IDLE;
      width_q  <= MAC_W16;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      acc_q    <= '0;
      sgn_q    <= 1'b0;
      sub_q    <= 1'b0;
      sat_q    <= 1'b0;
      rnd_q    <= 1'b0;
      ov_q     <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else if (state_q != MAC_IDLE && mac_if.kill_i) begin
      state_q <= MAC_IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        MAC_IDLE: begin
          if (mac_if.valid_i && !mac_if.kill_i) begin
            state_q  <= MAC_LANE;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ov_q     <= 1'b0;
            a_q      <= mac_if.op_a_i;
            b_q      <= mac_if.op_b_i;
            c_q      <= mac_if.op_c_i;
            width_q  <= mac_if.width32_i ? MAC_W32 : (mac_if.width8_i ? MAC_W8 : MAC_W16);
            sgn_q    <= mac_if.signed_ops_i;
            sub_q    <= mac_if.sub_i;
            sat_q    <= mac_if.sat_i;
            rnd_q    <= mac_if.rounding_i & RoundEnable;
          end
        end
        MAC_LANE: begin
          if (width_q == MAC_W32) begin
            acc_q <= acc_d;
            if (last_lane) state_q <= MAC_FIN;
          end else begin
            result_q <= lane_result_d;
            ov_q     <= ov_q | lane_ov;
            if (last_lane) begin
              state_q <= MAC_DONE;
              valid_q <= 1'b1;
            end
          end
          cnt_q <= cnt_q + 2'd1;
        end
        MAC_FIN: begin
          result_q <= fin_res;
          ov_q     <= fin_ov;
          state_q  <= MAC_DONE;
          valid_q  <= 1'b1;
        end
        default: begin
          if (mac_if.ready_i) begin
            state_q <= MAC_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mac_if.ready_o  = ready_q;
  assign mac_if.valid_o  = valid_q;
  assign mac_if.result_o = result_q;
  assign mac_if.ov_set_o = ov_q & valid_q;

endmodule

// File: tb/tb_ibex_pext_simd_mac.sv
// Directed bench for ibex_pext_simd_mac; a second instance with rounding
// disabled runs in lockstep on the same stimulus.
module tb_ibex_pext_simd_mac;

  logic clk = 1'b0;
  logic rst_n;
  logic valid, kill, rdy, w32, w8, sgn, sub, sat, rnd;
  logic [31:0] a, b, c;
  int n_chk = 0;
  int n_err = 0;
  int lat;

  always #5 clk = ~clk;

  ibex_pext_simd_mac_if mif ();
  ibex_pext_simd_mac_if nif ();

  assign mif.valid_i = valid;      assign nif.valid_i = valid;
  assign mif.kill_i = kill;        assign nif.kill_i = kill;
  assign mif.ready_i = rdy;        assign nif.ready_i = rdy;
  assign mif.op_a_i = a;           assign nif.op_a_i = a;
  assign mif.op_b_i = b;           assign nif.op_b_i = b;
  assign mif.op_c_i = c;           assign nif.op_c_i = c;
  assign mif.width32_i = w32;      assign nif.width32_i = w32;
  assign mif.width8_i = w8;        assign nif.width8_i = w8;
  assign mif.signed_ops_i = sgn;   assign nif.signed_ops_i = sgn;
  assign mif.sub_i = sub;          assign nif.sub_i = sub;
  assign mif.sat_i = sat;          assign nif.sat_i = sat;
  assign mif.rounding_i = rnd;     assign nif.rounding_i = rnd;

  ibex_pext_simd_mac dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .mac_if (mif)
  );

  ibex_pext_simd_mac #(.RoundEnable(1'b0)) dut_nr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .mac_if (nif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic iw32, input logic iw8, input logic isgn, input logic isub,
                        input logic isat, input logic irnd,
                        input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ic);
    w32 = iw32; w8 = iw8; sgn = isgn; sub = isub; sat = isat; rnd = irnd;
    a = ia; b = ib; c = ic;
  endtask

  task automatic start(input string tag);
    chk({tag, "_ready_before_accept"}, {31'd0, mif.ready_o}, 32'd1);
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (mif.valid_o !== 1'b1 && l < 50) begin
      tick();
      l++;
    end
  endtask

  task automatic consume(input string tag);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk({tag, "_valid_after_hs"}, {31'd0, mif.valid_o}, 32'd0);
    chk({tag, "_ready_after_hs"}, {31'd0, mif.ready_o}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; kill = 1'b0; rdy = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, mif.valid_o}, 32'd0);
    chk("reset_ready", {31'd0, mif.ready_o}, 32'd1);
    chk("reset_result", mif.result_o, 32'h0);
    chk("reset_ov", {31'd0, mif.ov_set_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 16-bit signed add, saturating
    set_op(0, 0, 1, 0, 1, 0, 32'h7FFF_8000, 32'h7FFF_8000, 32'h7FF0_0000);
    start("s16");
    wait_valid(lat);
    chk("s16_latency", lat, 2);
    chk("s16_result", mif.result_o, 32'h7FFF_4000);
    chk("s16_ov", {31'd0, mif.ov_set_o}, 32'd1);
    consume("s16");

    // 8-bit unsigned sub, wrapping
    set_op(0, 1, 0, 1, 0, 0, 32'h1010_1010, 32'h1010_1010, 32'h0005_0A0F);
    start("u8w");
    wait_valid(lat);
    chk("u8w_latency", lat, 4);
    chk("u8w_result", mif.result_o, 32'hFF04_090E);
    chk("u8w_ov", {31'd0, mif.ov_set_o}, 32'd0);
    consume("u8w");

    // 8-bit unsigned sub, saturating
    set_op(0, 1, 0, 1, 1, 0, 32'h1010_1010, 32'h1010_1010, 32'h0005_0A0F);
    start("u8s");
    wait_valid(lat);
    chk("u8s_latency", lat, 4);
    chk("u8s_result", mif.result_o, 32'h0004_090E);
    chk("u8s_ov", {31'd0, mif.ov_set_o}, 32'd1);
    consume("u8s");

    // 32-bit signed add, saturating
    set_op(1, 0, 1, 0, 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    start("s32");
    wait_valid(lat);
    chk("s32_latency", lat, 5);
    chk("s32_result", mif.result_o, 32'h7FFF_FFFF);
    chk("s32_ov", {31'd0, mif.ov_set_o}, 32'd1);
    consume("s32");

    // 32-bit unsigned rounding; dut_nr ignores rounding
    set_op(1, 0, 0, 0, 0, 1, 32'h0001_0000, 32'h0000_8000, 32'h0);
    start("r32");
    wait_valid(lat);
    chk("r32_latency", lat, 5);
    chk("r32_result_round", mif.result_o, 32'h0000_0001);
    chk("r32_result_roundoff", nif.result_o, 32'h0000_0000);
    consume("r32");
    set_op(1, 0, 0, 0, 0, 0, 32'h0001_0000, 32'h0000_8000, 32'h0);
    start("t32");
    wait_valid(lat);
    chk("t32_result", mif.result_o, 32'h0000_0000);
    consume("t32");

    // 32-bit with both width bits set behaves as 32-bit
    set_op(1, 1, 1, 0, 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    start("w32w8");
    wait_valid(lat);
    chk("w32w8_latency", lat, 5);
    chk("w32w8_result", mif.result_o, 32'h7FFF_FFFF);
    consume("w32w8");

    // Backpressure with a competing request while waiting
    set_op(0, 0, 1, 0, 1, 0, 32'h7FFF_8000, 32'h7FFF_8000, 32'h7FF0_0000);
    start("bp");
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      set_op(0, 1, 0, 1, 0, 0, 32'h1010_1010, 32'h1010_1010, 32'h0005_0A0F);
      valid = 1'b1;
      tick();
      chk("bp_result_hold", mif.result_o, 32'h7FFF_4000);
      chk("bp_ov_hold", {31'd0, mif.ov_set_o}, 32'd1);
      chk("bp_valid_hold", {31'd0, mif.valid_o}, 32'd1);
      chk("bp_ready_low", {31'd0, mif.ready_o}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    valid = 1'b0;
    chk("bp_valid_after_hs", {31'd0, mif.valid_o}, 32'd0);
    chk("bp_ready_after_hs", {31'd0, mif.ready_o}, 32'd1);
    tick();
    chk("bp_not_accepted", {31'd0, mif.ready_o}, 32'd1);

    // Kill in lane 1 of an 8-bit op
    set_op(0, 1, 0, 1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    start("kl");
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_valid", {31'd0, mif.valid_o}, 32'd0);
    chk("kill_ready", {31'd0, mif.ready_o}, 32'd1);
    repeat (4) tick();
    chk("kill_no_late_valid", {31'd0, mif.valid_o}, 32'd0);
    set_op(0, 1, 0, 1, 1, 0, 32'h1010_1010, 32'h1010_1010, 32'h0005_0A0F);
    start("kl_next");
    wait_valid(lat);
    chk("kl_next_latency", lat, 4);
    chk("kl_next_result", mif.result_o, 32'h0004_090E);
    chk("kl_next_ov", {31'd0, mif.ov_set_o}, 32'd1);

    // Kill with ready in MAC_DONE: kill wins
    kill = 1'b1;
    rdy = 1'b1;
    tick();
    kill = 1'b0;
    rdy = 1'b0;
    chk("kdone_valid", {31'd0, mif.valid_o}, 32'd0);
    chk("kdone_ov", {31'd0, mif.ov_set_o}, 32'd0);
    chk("kdone_ready", {31'd0, mif.ready_o}, 32'd1);

    // Kill in MAC_IDLE blocks a simultaneous request
    valid = 1'b1;
    kill = 1'b1;
    tick();
    valid = 1'b0;
    kill = 1'b0;
    chk("kidle_ready", {31'd0, mif.ready_o}, 32'd1);
    repeat (5) tick();
    chk("kidle_no_valid", {31'd0, mif.valid_o}, 32'd0);

    // Reset in lane 1 of an 8-bit op
    set_op(0, 1, 0, 1, 0, 0, 32'h1010_1010, 32'h1010_1010, 32'h0005_0A0F);
    start("rs");
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_valid", {31'd0, mif.valid_o}, 32'd0);
    chk("rs_ready", {31'd0, mif.ready_o}, 32'd1);
    chk("rs_result", mif.result_o, 32'h0);
    chk("rs_ov", {31'd0, mif.ov_set_o}, 32'd0);
    start("rs_next");
    wait_valid(lat);
    chk("rs_next_latency", lat, 4);
    chk("rs_next_result", mif.result_o, 32'hFF04_090E);
    consume("rs_next");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ibex_pext_simd_mac.md
Name: ibex_pext_simd_mac

Overview:
- Multi-cycle SIMD multiply-accumulate execution unit for P-extension (Zpn) ops.
- Consumes the decoded control set produced by the Zpn decode stage: width32/width8/signed/sub/sat/rounding.
- Processes one lane per cycle on a single shared 17x17 signed multiplier, then accumulates into op_c with optional saturation.
- Sits beside the ALU in EX; returns its result and an OV (vxsat) set pulse to the writeback/CSR path.

Parameters:
- RoundEnable, 1'b1, when 0 rounding_i is ignored and treated as 0.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, synchronous, active-low
- valid_i  input  1  operation request
- ready_o  output  1  unit can accept a request
- kill_i  input  1  abort in-flight operation (flush)
- op_a_i  input  32  multiplicand lanes
- op_b_i  input  32  multiplier lanes
- op_c_i  input  32  accumulator lanes
- width32_i  input  1  32-bit lane mode
- width8_i  input  1  8-bit lane mode; 16-bit mode when both width inputs are 0
- signed_ops_i  input  1  signed lanes
- sub_i  input  1  accumulate = c - p; else c + p
- sat_i  input  1  saturate accumulation; else wrap
- rounding_i  input  1  round product before truncation
- valid_o  output  1  result available
- ready_i  input  1  consumer accepts result
- result_o  output  32  packed lane results
- ov_set_o  output  1  at least one lane saturated; qualified by valid_o

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - state MAC_IDLE.
  - valid_o=0, ready_o=1, result_o=0, ov_set_o=0.
  - all internal lane/partial registers cleared.
  - Reset mid-operation discards the operation.
- Input handshake:
  - Accept on valid_i & ready_o.
  - ready_o=1 only in MAC_IDLE.
  - Operands and controls are captured on acceptance; the request inputs are don't-care afterwards.
- Lane ordering: 8-bit lanes = 4 (bits [7:0] first); 16-bit lanes = 2; 32-bit = 1 lane built from 4 16x16 partial products (lo*lo, lo*hi, hi*lo, hi*hi).
- Per-lane product p, for lane width W:
  - Full 2W-bit product, sign-/zero-extended per signed_ops.
  - If rounding, add 1<<(W-1).
  - Take bits [2W-1:W] (high half, W bits, extended to W+1 for the accumulate step).
- Accumulate:
  - r = c ± p computed at W+2 bits.
  - sat=1 signed: clamp to [-2^(W-1), 2^(W-1)-1].
  - sat=1 unsigned: clamp to [0, 2^W-1].
  - sat=0: keep low W bits; ov is never set.
- FSM:
  - MAC_IDLE -> MAC_LANE on accept; lane counter = 0.
  - MAC_LANE:
    - 8/16-bit: one lane result is written per cycle.
    - 32-bit: one partial product is accumulated into a 66-bit register per cycle.
    - After the last step, 8/16-bit go to MAC_DONE; 32-bit goes to MAC_FIN.
  - MAC_FIN: 32-bit round/truncate/accumulate/saturate -> MAC_DONE.
  - MAC_DONE: valid_o=1; result_o and ov_set_o held stable until ready_i; on ready_i -> MAC_IDLE.
- Latency, counted from the acceptance edge to valid_o high: 4 cycles (8-bit), 2 cycles (16-bit), 5 cycles (32-bit).
- ov_set_o is the OR of lane saturations; it is only meaningful while valid_o=1 and is consumed when valid_o & ready_i.
- kill_i:
  - In any state other than MAC_IDLE, kill_i forces MAC_IDLE next cycle.
  - No valid_o is produced and ov_set_o is not reported.
  - kill_i in MAC_DONE with ready_i in the same cycle: kill wins, no handshake.
  - kill_i in MAC_IDLE is ignored, and a simultaneous valid_i is not accepted.
- width32_i & width8_i both 1 is illegal; the unit treats it as 32-bit mode.
- No new request is accepted in the cycle valid_o handshakes; ready_o rises the following cycle.

Decomposition:
- ibex_pkg_pext:
  - typedef enum pext_mac_state_e {MAC_IDLE, MAC_LANE, MAC_FIN, MAC_DONE}.
  - Lane-count constants: PEXT_LANES8=4, PEXT_LANES16=2, PEXT_PP32=4.
- One sub-module: ibex_pext_mul17, a combinational 17x17 signed multiplier (operands pre-extended by the caller), so it can later be shared with the MD unit.

Test Plan:
- 16-bit, signed, add, sat, round=0: a=0x7FFF_8000, b=0x7FFF_8000, c=0x7FF0_0000 -> result 0x7FFF_4000, ov_set_o=1, valid_o 2 cycles after accept.
- 8-bit, unsigned, sub, round=0, a=b=0x10101010, c=0x00050A0F:
  - sat=0 -> 0xFF04090E, ov=0.
  - sat=1 -> 0x0004090E, ov=1.
  - valid_o 4 cycles after accept.
- 32-bit, signed, add, sat: a=b=0x80000000, c=0x40000000 -> 0x7FFFFFFF, ov=1, valid_o 5 cycles after accept.
- 32-bit rounding, unsigned, add: a=0x00010000, b=0x00008000, c=0.
  - rounding=1 -> result 0x00000001.
  - rounding=0 -> result 0x00000000.
  - RoundEnable=0 with rounding=1 -> result 0x00000000.
- Backpressure: hold ready_i=0 for 3 cycles in MAC_DONE -> result_o/ov_set_o stable, ready_o=0, concurrent valid_i not accepted; ready_i=1 -> MAC_IDLE, ready_o=1 next cycle.
- Kill/reset: kill_i in lane 1 of an 8-bit op -> no valid_o, ready_o=1 next cycle, next op correct. Repeat with rst_ni=0 instead of kill_i -> all outputs at reset values.
